// File: rtl/date_pkg.sv
// Shared calendar widths, month numbers and the month-length rule used by
// both the advance path and the load check.
package date_pkg;

    localparam int DAY_W  = 5;
    localparam int MON_W  = 4;
    localparam int YEAR_W = 7;

    localparam logic [MON_W-1:0] JAN = 4'd1;
    localparam logic [MON_W-1:0] FEB = 4'd2;
    localparam logic [MON_W-1:0] MAR = 4'd3;
    localparam logic [MON_W-1:0] APR = 4'd4;
    localparam logic [MON_W-1:0] MAY = 4'd5;
    localparam logic [MON_W-1:0] JUN = 4'd6;
    localparam logic [MON_W-1:0] JUL = 4'd7;
    localparam logic [MON_W-1:0] AUG = 4'd8;
    localparam logic [MON_W-1:0] SEP = 4'd9;
    localparam logic [MON_W-1:0] OCT = 4'd10;
    localparam logic [MON_W-1:0] NOV = 4'd11;
    localparam logic [MON_W-1:0] DEC = 4'd12;

    // Year 0 is 2000, so every year divisible by four within the century is leap.
    function automatic logic [DAY_W-1:0] month_len(input logic [MON_W-1:0]  mon,
                                                   input logic [YEAR_W-1:0] year);
        logic [DAY_W-1:0] len;
        case (mon)
            JAN, MAR, MAY, JUL, AUG, OCT, DEC: len = 5'd31;
            APR, JUN, SEP, NOV:                len = 5'd30;
            FEB:                               len = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                           len = 5'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/month_days.sv
// Combinational month-length lookup; returns 0 for an invalid month number.
module month_days
    import date_pkg::*;
(
    input  logic [MON_W-1:0]  mon_i,
    input  logic [YEAR_W-1:0] year_i,
    output logic [DAY_W-1:0]  days_o
);

    assign days_o = month_len(mon_i, year_i);

endmodule

// File: rtl/date_counter.sv
// Calendar register: advances one day per inc_day pulse, accepts validated
// parallel loads, and emits month/year/century rollover ticks.
module date_counter
    import date_pkg::*;
#(
    parameter int YEAR_MAX = 99,
    parameter int RST_DAY  = 1,
    parameter int RST_MON  = 1,
    parameter int RST_YEAR = 0
) (
    input  logic              clk_1Hz,
    input  logic              rst,
    input  logic              inc_day,
    input  logic              load,
    input  logic [DAY_W-1:0]  ld_day,
    input  logic [MON_W-1:0]  ld_mon,
    input  logic [YEAR_W-1:0] ld_year,
    output logic [DAY_W-1:0]  out_day,
    output logic [MON_W-1:0]  out_mon,
    output logic [YEAR_W-1:0] out_year,
    output logic              month_tick,
    output logic              year_tick,
    output logic              century_tick,
    output logic              load_err
);

    localparam logic [YEAR_W-1:0] YMAX = YEAR_W'(YEAR_MAX);

    logic [DAY_W-1:0]  day_q, day_d;
    logic [MON_W-1:0]  mon_q, mon_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic              month_tick_q, month_tick_d;
    logic              year_tick_q, year_tick_d;
    logic              century_tick_q, century_tick_d;
    logic              load_err_q, load_err_d;

    logic [DAY_W-1:0]  cur_len;
    logic [DAY_W-1:0]  ld_len;
    logic              ld_valid;

    month_days u_cur_days (
        .mon_i  (mon_q),
        .year_i (year_q),
        .days_o (cur_len)
    );

    month_days u_ld_days (
        .mon_i  (ld_mon),
        .year_i (ld_year),
        .days_o (ld_len)
    );

    // An out-of-range month yields ld_len == 0, which also fails the day check.
    assign ld_valid = (ld_mon >= JAN) && (ld_mon <= DEC) && (ld_year <= YMAX)
                   && (ld_day != '0) && (ld_day <= ld_len);

    always_comb begin
        day_d          = day_q;
        mon_d          = mon_q;
        year_d         = year_q;
        month_tick_d   = 1'b0;
        year_tick_d    = 1'b0;
        century_tick_d = 1'b0;
        load_err_d     = 1'b0;

        if (load) begin
            if (ld_valid) begin
                day_d  = ld_day;
                mon_d  = ld_mon;
                year_d = ld_year;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (inc_day) begin
            // Using >= lets a stale day beyond the month length recover in one step.
            if (day_q < cur_len) begin
                day_d = day_q + 1'b1;
            end else begin
                day_d        = 5'd1;
                month_tick_d = 1'b1;
                if (mon_q < DEC) begin
                    mon_d = mon_q + 1'b1;
                end else begin
                    mon_d       = JAN;
                    year_tick_d = 1'b1;
                    if (year_q == YMAX) begin
                        year_d         = '0;
                        century_tick_d = 1'b1;
                    end else begin
                        year_d = year_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_1Hz) begin
        if (rst) begin
            day_q          <= DAY_W'(RST_DAY);
            mon_q          <= MON_W'(RST_MON);
            year_q         <= YEAR_W'(RST_YEAR);
            month_tick_q   <= 1'b0;
            year_tick_q    <= 1'b0;
            century_tick_q <= 1'b0;
            load_err_q     <= 1'b0;
        end else begin
            day_q          <= day_d;
            mon_q          <= mon_d;
            year_q         <= year_d;
            month_tick_q   <= month_tick_d;
            year_tick_q    <= year_tick_d;
            century_tick_q <= century_tick_d;
            load_err_q     <= load_err_d;
        end
    end

    assign out_day      = day_q;
    assign out_mon      = mon_q;
    assign out_year     = year_q;
    assign month_tick   = month_tick_q;
    assign year_tick    = year_tick_q;
    assign century_tick = century_tick_q;
    assign load_err     = load_err_q;

endmodule

// File: tb/tb_date_counter.sv
// Directed bench for date_counter: a calendar-arithmetic model checked every
// cycle, plus literal expectations for the named calendar scenarios.
module tb_date_counter;

    logic       clk_1Hz = 1'b0;
    logic       rst = 1'b0;
    logic       inc_day = 1'b0;
    logic       load = 1'b0;
    logic [4:0] ld_day = '0;
    logic [3:0] ld_mon = '0;
    logic [6:0] ld_year = '0;
    logic [4:0] out_day;
    logic [3:0] out_mon;
    logic [6:0] out_year;
    logic       month_tick, year_tick, century_tick, load_err;

    int errors = 0;
    int checks = 0;
    bit checking = 0;

    int m_day = 1, m_mon = 1, m_year = 0;
    int m_mt = 0, m_yt = 0, m_ct = 0, m_err = 0;

    date_counter #(.YEAR_MAX(99), .RST_DAY(1), .RST_MON(1), .RST_YEAR(0)) dut (
        .clk_1Hz      (clk_1Hz),
        .rst          (rst),
        .inc_day      (inc_day),
        .load         (load),
        .ld_day       (ld_day),
        .ld_mon       (ld_mon),
        .ld_year      (ld_year),
        .out_day      (out_day),
        .out_mon      (out_mon),
        .out_year     (out_year),
        .month_tick   (month_tick),
        .year_tick    (year_tick),
        .century_tick (century_tick),
        .load_err     (load_err)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    function automatic int days_in(int mon, int year);
        int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (mon < 1 || mon > 12) return 0;
        if (mon == 2 && (year % 4) == 0) return 29;
        return tbl[mon-1];
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(bit r, bit inc, bit ld, int d, int m, int y);
        m_mt = 0; m_yt = 0; m_ct = 0; m_err = 0;
        if (r) begin
            m_day = 1; m_mon = 1; m_year = 0;
        end else if (ld) begin
            if (m >= 1 && m <= 12 && y <= 99 && d >= 1 && d <= days_in(m, y)) begin
                m_day = d; m_mon = m; m_year = y;
            end else begin
                m_err = 1;
            end
        end else if (inc) begin
            m_day++;
            if (m_day > days_in(m_mon, m_year)) begin
                m_day = 1; m_mon++; m_mt = 1;
                if (m_mon > 12) begin
                    m_mon = 1; m_year++; m_yt = 1;
                    if (m_year > 99) begin
                        m_year = 0; m_ct = 1;
                    end
                end
            end
        end
    endtask

    task automatic cyc(bit r, bit inc, bit ld, int d = 0, int m = 0, int y = 0);
        rst = r; inc_day = inc; load = ld;
        ld_day = 5'(d); ld_mon = 4'(m); ld_year = 7'(y);
        @(posedge clk_1Hz);
        model_step(r, inc, ld, d, m, y);
        #1;
        rst = 0; inc_day = 0; load = 0;
    endtask

    task automatic lit_date(string name, int d, int m, int y);
        chk({name, ".day"}, int'(out_day), d);
        chk({name, ".mon"}, int'(out_mon), m);
        chk({name, ".year"}, int'(out_year), y);
    endtask

    task automatic lit_flags(string name, int mt, int yt, int ct, int er);
        chk({name, ".month_tick"}, int'(month_tick), mt);
        chk({name, ".year_tick"}, int'(year_tick), yt);
        chk({name, ".century_tick"}, int'(century_tick), ct);
        chk({name, ".load_err"}, int'(load_err), er);
    endtask

    always @(negedge clk_1Hz) begin
        if (checking) begin
            chk("model.day", int'(out_day), m_day);
            chk("model.mon", int'(out_mon), m_mon);
            chk("model.year", int'(out_year), m_year);
            chk("model.month_tick", int'(month_tick), m_mt);
            chk("model.year_tick", int'(year_tick), m_yt);
            chk("model.century_tick", int'(century_tick), m_ct);
            chk("model.load_err", int'(load_err), m_err);
        end
    end

    initial begin
        cyc(1, 0, 0);
        checking = 1;
        cyc(1, 0, 0);
        lit_date("reset", 1, 1, 0);
        lit_flags("reset", 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0);
        lit_date("hold", 1, 1, 0);

        cyc(0, 0, 1, 30, 4, 23);
        lit_date("load_apr", 30, 4, 23);
        lit_flags("load_apr", 0, 0, 0, 0);
        cyc(0, 1, 0);
        lit_date("apr_end", 1, 5, 23);
        lit_flags("apr_end", 1, 0, 0, 0);
        cyc(0, 0, 0);
        lit_flags("apr_end_after", 0, 0, 0, 0);

        cyc(0, 0, 1, 31, 5, 23);
        cyc(0, 1, 0);
        lit_date("may_end", 1, 6, 23);

        cyc(0, 0, 1, 28, 2, 23);
        cyc(0, 1, 0);
        lit_date("feb23", 1, 3, 23);

        cyc(0, 0, 1, 28, 2, 24);
        cyc(0, 1, 0);
        lit_date("feb24_29", 29, 2, 24);
        lit_flags("feb24_29", 0, 0, 0, 0);
        cyc(0, 1, 0);
        lit_date("feb24_end", 1, 3, 24);

        cyc(0, 0, 1, 28, 2, 0);
        cyc(0, 1, 0);
        lit_date("feb00_29", 29, 2, 0);

        cyc(0, 0, 1, 31, 12, 99);
        cyc(0, 1, 0);
        lit_date("century", 1, 1, 0);
        lit_flags("century", 1, 1, 1, 0);
        cyc(0, 0, 0);
        lit_flags("century_after", 0, 0, 0, 0);

        cyc(0, 0, 1, 29, 2, 23);
        lit_date("rej_feb29", 1, 1, 0);
        lit_flags("rej_feb29", 0, 0, 0, 1);
        cyc(0, 0, 0);
        lit_flags("rej_after", 0, 0, 0, 0);
        cyc(0, 0, 1, 10, 13, 23);
        lit_flags("rej_mon13", 0, 0, 0, 1);
        lit_date("rej_mon13", 1, 1, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 1, 0, 3, 23);
        lit_flags("rej_day0", 0, 0, 0, 1);
        lit_date("rej_day0", 1, 1, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 1, 10, 3, 100);
        lit_flags("rej_yr100", 0, 0, 0, 1);
        lit_date("rej_yr100", 1, 1, 0);
        cyc(0, 0, 1, 31, 4, 23);
        lit_flags("rej_apr31", 0, 0, 0, 1);

        cyc(0, 1, 1, 15, 8, 50);
        lit_date("load_inc", 15, 8, 50);
        lit_flags("load_inc", 0, 0, 0, 0);
        cyc(0, 0, 0);
        lit_date("load_inc_hold", 15, 8, 50);

        cyc(1, 1, 0);
        lit_date("rst_inc", 1, 1, 0);
        cyc(0, 0, 1, 20, 6, 40);
        cyc(1, 0, 1, 21, 6, 40);
        lit_date("rst_load", 1, 1, 0);

        cyc(0, 0, 1, 31, 1, 96);
        lit_date("sweep_load", 31, 1, 96);
        for (int i = 0; i < 1600; i++) begin
            cyc(0, (i % 3) != 2, 0);
        end

        cyc(0, 0, 1, 31, 7, 60);
        cyc(0, 1, 0);
        cyc(1, 0, 0);
        lit_date("rst_mid", 1, 1, 0);
        lit_flags("rst_mid", 0, 0, 0, 0);

        @(negedge clk_1Hz);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
